// File: rtl/dm_pkg.sv
// Shared types and constants for the data-memory responder.
// State encoding, bus widths, error codes and a lane-count helper.
package dm_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_COMMIT,
    S_RESP
  } state_e;

  localparam logic ERR_NONE   = 1'b0;
  localparam logic ERR_ACCESS = 1'b1;

  function automatic logic multi_lane(logic [BE_W-1:0] be);
    return (be & (be - BE_W'(1))) != '0;
  endfunction

endpackage

// File: rtl/dm_responder_if.sv
// Request/response channel between the CPU memory port and the responder.
// master = CPU side, slave = responder side.
interface dm_responder_if;
  import dm_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [BE_W-1:0]   req_be;
  logic [DATA_W-1:0] req_wdata;
  logic [ADDR_W-1:0] req_pc;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr,
    output req_be, req_wdata, req_pc,
    output rsp_ready,
    input  req_ready, rsp_valid,
    input  rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr,
    input  req_be, req_wdata, req_pc,
    input  rsp_ready,
    output req_ready, rsp_valid,
    output rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dm_byte_merge.sv
// Byte-lane merge of a stored word with new store data.
// Lanes with be set take wdata, the rest keep the old word.
module dm_byte_merge
  import dm_pkg::*;
(
  input  logic [DATA_W-1:0] old_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [BE_W-1:0]   be_i,
  output logic [DATA_W-1:0] merged_o
);

  // Select each byte from wdata or the old word
  always_comb begin
    merged_o = old_i;
    for (int i = 0; i < BE_W; i++) begin
      if (be_i[i]) merged_o[8*i +: 8] = wdata_i[8*i +: 8];
    end
  end

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: one request at a time, wait states, word array.
// Optional DM_WRITE_LOG_EN prints each committed store (pc, addr, word).
module dm_responder
  import dm_pkg::*;
#(
  parameter int unsigned       DEPTH_WORDS = 3072,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned       WAIT_CYCLES = 1
) (
  input logic           clk,
  input logic           reset,
  dm_responder_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_N = 4'(WAIT_CYCLES);

  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [BE_W-1:0]   be_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  logic [29:0]       idx;
  logic [IDX_W-1:0]  mem_idx;
  logic              err;
  logic [DATA_W-1:0] old_word;
  logic [DATA_W-1:0] merged;
  logic              accept;

  assign accept  = (state_q == S_IDLE) && bus.req_valid;
  assign idx     = 30'((addr_q - BASE_ADDR) >> 2);
  assign mem_idx = idx[IDX_W-1:0];

  assign err = (addr_q < BASE_ADDR)
            || (32'(idx) >= DEPTH_WORDS)
            || (multi_lane(be_q) && addr_q[1:0] != 2'b00)
            || (we_q && be_q == '0);

  assign old_word = err ? '0 : mem[mem_idx];

  dm_byte_merge u_merge (
    .old_i    (old_word),
    .wdata_i  (wdata_q),
    .be_i     (be_q),
    .merged_o (merged)
  );

  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

  // State and wait counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, wait counting and handshake outputs
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          cnt_d   = '0;
          state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_COMMIT;
        end
      end
      S_WAIT: begin
        if (cnt_q + 4'd1 == WAIT_N) begin
          cnt_d   = '0;
          state_d = S_COMMIT;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_COMMIT: state_d = S_RESP;
      S_RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Capture the request only when it is accepted in IDLE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      we_q    <= bus.req_we;
      addr_q  <= bus.req_addr;
      be_q    <= bus.req_be;
      wdata_q <= bus.req_wdata;
    end
  end

  // Response word and error flag, produced at the commit edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_q <= '0;
      err_q   <= ERR_NONE;
    end else if (state_q == S_COMMIT) begin
      err_q <= err ? ERR_ACCESS : ERR_NONE;
      if (err)       rdata_q <= '0;
      else if (we_q) rdata_q <= merged;
      else           rdata_q <= old_word;
    end
  end

  // Array write; contents survive reset
  always_ff @(posedge clk) begin
    if (state_q == S_COMMIT && we_q && !err) mem[mem_idx] <= merged;
  end

`ifdef DM_WRITE_LOG_EN
  logic [ADDR_W-1:0] pc_q;

  // Issuing PC, kept only for the store log
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      pc_q <= '0;
    else if (accept) pc_q <= bus.req_pc;
  end

  // Log each committed store
  always_ff @(posedge clk) begin
    if (reset && state_q == S_COMMIT && we_q && !err)
      $display("@%h: *%h <= %h", pc_q, {addr_q[31:2], 2'b00}, merged);
  end
`endif

endmodule
